// File: rtl/mem_ctrler_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrler_pkg
// Shared types and helpers for the byte-wide memory controller.
//   state_t    : controller FSM states
//   addr_t     : 32-bit byte address
//   lsu_bytes  : number of bytes moved for a given LSU length code
//   is_io      : true when an address region field selects the IO window
// -----------------------------------------------------------------------------
package mem_ctrler_pkg;

  localparam int ADDR_W = 32;
  localparam int REG_W  = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [REG_W-1:0]  reg_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_READ  = 2'd1,
    LS_READ  = 2'd2,
    LS_WRITE = 2'd3
  } state_t;

  // Length code is bytes-1; the illegal code 2 naturally becomes 3 bytes.
  function automatic logic [2:0] lsu_bytes(input logic [1:0] len);
    return {1'b0, len} + 3'd1;
  endfunction

  function automatic logic is_io(input logic [1:0] region, input logic [1:0] io_hi);
    return region == io_hi;
  endfunction

endpackage

// File: rtl/mem_ctrler.sv
// -----------------------------------------------------------------------------
// mem_ctrler
// Sole owner of the byte-wide synchronous RAM/IO port. Serialises icache line
// fills and LSU loads/stores into one RAM byte cycle each, little-endian.
// Ports:
//   clk, rst (sync, active-low), rdy (global enable; freezes all state)
//   valid/addr_from_inst_fetcher  -> ready_to_inst_fetcher, cache_line_to_inst_fetcher
//   valid/wr/addr/len/data_from_lsu -> ready_to_lsu, data_to_lsu
//   mem_din (read byte, one cycle after address), mem_dout, mem_a, mem_wr
//   io_buffer_full (stalls stores into the IO region)
// -----------------------------------------------------------------------------
module mem_ctrler
  import mem_ctrler_pkg::*;
#(
  parameter int         LINE_BYTES = 16,
  parameter logic [1:0] IO_BASE_HI = 2'b11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    valid_from_inst_fetcher,
  input  logic [31:0]             addr_from_inst_fetcher,
  output logic                    ready_to_inst_fetcher,
  output logic [LINE_BYTES*8-1:0] cache_line_to_inst_fetcher,
  input  logic                    valid_from_lsu,
  input  logic                    wr_from_lsu,
  input  logic [31:0]             addr_from_lsu,
  input  logic [1:0]              len_from_lsu,
  input  logic [31:0]             data_from_lsu,
  output logic                    ready_to_lsu,
  output logic [31:0]             data_to_lsu,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  // Counter must reach LINE_BYTES+1 (the last capture edge of a line fill).
  localparam int CNT_W = OFF_W + 2;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
  localparam addr_t LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nbytes;
  addr_t            base;
  reg_t             wdata;
  logic             io_wr;
  logic [OFF_W-1:0] idx;

  // Read byte k arrives on mem_din two edges after its address was issued,
  // so the byte being captured at count c is byte c-2.
  assign idx = OFF_W'(cnt - TWO);

  // Single FSM: accepts one request in IDLE, then walks the byte counter.
  // Reads issue an address every edge and capture two edges later; writes
  // present one byte per edge unless an IO store is stalled by a full buffer.
  // A ready pulse marks completion; no request is accepted while a pulse is
  // still high so a requester dropping valid at that edge is not re-served.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state                      <= IDLE;
      cnt                        <= '0;
      nbytes                     <= '0;
      base                       <= '0;
      wdata                      <= '0;
      io_wr                      <= 1'b0;
      ready_to_inst_fetcher      <= 1'b0;
      cache_line_to_inst_fetcher <= '0;
      ready_to_lsu               <= 1'b0;
      data_to_lsu                <= '0;
      mem_dout                   <= '0;
      mem_a                      <= '0;
      mem_wr                     <= 1'b0;
    end else if (!rdy) begin
      // Frozen: keep everything, but never let a presented write repeat.
      mem_wr <= 1'b0;
    end else begin
      ready_to_inst_fetcher <= 1'b0;
      ready_to_lsu          <= 1'b0;
      mem_wr                <= 1'b0;

      case (state)
        IDLE: begin
          if (!ready_to_lsu && !ready_to_inst_fetcher) begin
            if (valid_from_lsu) begin
              base   <= addr_from_lsu;
              nbytes <= CNT_W'(lsu_bytes(len_from_lsu));
              wdata  <= data_from_lsu;
              io_wr  <= is_io(addr_from_lsu[17:16], IO_BASE_HI);
              mem_a  <= addr_from_lsu;
              if (wr_from_lsu) begin
                state <= LS_WRITE;
                if (is_io(addr_from_lsu[17:16], IO_BASE_HI) && io_buffer_full) begin
                  cnt <= '0;
                end else begin
                  mem_dout <= data_from_lsu[7:0];
                  mem_wr   <= 1'b1;
                  cnt      <= ONE;
                end
              end else begin
                state       <= LS_READ;
                data_to_lsu <= '0;
                cnt         <= ONE;
              end
            end else if (valid_from_inst_fetcher) begin
              state  <= IF_READ;
              base   <= addr_from_inst_fetcher & LINE_MASK;
              mem_a  <= addr_from_inst_fetcher & LINE_MASK;
              nbytes <= CNT_W'(LINE_BYTES);
              cnt    <= ONE;
            end
          end
        end

        IF_READ, LS_READ: begin
          if (cnt < nbytes) begin
            mem_a <= base + ADDR_W'(cnt);
          end
          if (cnt >= TWO) begin
            if (state == IF_READ) begin
              cache_line_to_inst_fetcher[{idx, 3'b000} +: 8] <= mem_din;
            end else begin
              data_to_lsu[{idx[1:0], 3'b000} +: 8] <= mem_din;
            end
          end
          if (cnt == nbytes + ONE) begin
            state <= IDLE;
            cnt   <= '0;
            if (state == IF_READ) begin
              ready_to_inst_fetcher <= 1'b1;
            end else begin
              ready_to_lsu <= 1'b1;
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end

        LS_WRITE: begin
          if (cnt == nbytes) begin
            state        <= IDLE;
            cnt          <= '0;
            ready_to_lsu <= 1'b1;
          end else if (io_wr && io_buffer_full) begin
            cnt <= cnt;
          end else begin
            mem_a    <= base + ADDR_W'(cnt);
            mem_dout <= wdata[{cnt[1:0], 3'b000} +: 8];
            mem_wr   <= 1'b1;
            cnt      <= cnt + ONE;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrler.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrler
// Directed bench for mem_ctrler. A behavioural RAM returns a[7:0]^8'h5A one
// cycle after the address edge. Expected responses and expected RAM writes are
// queued as each request is raised and popped by monitors on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_ctrler;

  localparam int LINE_BYTES = 16;
  localparam int LINE_W     = LINE_BYTES * 8;

  logic              clk;
  logic              rst;
  logic              rdy;
  logic              valid_from_inst_fetcher;
  logic [31:0]       addr_from_inst_fetcher;
  logic              ready_to_inst_fetcher;
  logic [LINE_W-1:0] cache_line_to_inst_fetcher;
  logic              valid_from_lsu;
  logic              wr_from_lsu;
  logic [31:0]       addr_from_lsu;
  logic [1:0]        len_from_lsu;
  logic [31:0]       data_from_lsu;
  logic              ready_to_lsu;
  logic [31:0]       data_to_lsu;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [31:0]       mem_a;
  logic              mem_wr;
  logic              io_buffer_full;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    bit                is_if;
    logic [LINE_W-1:0] line;
    logic [31:0]       data;
    bit                chk_data;
    int                exp_cyc;
  } resp_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  resp_t resp_q[$];
  wr_t   wr_q[$];

  mem_ctrler #(.LINE_BYTES(LINE_BYTES), .IO_BASE_HI(2'b11)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .rdy                        (rdy),
    .valid_from_inst_fetcher    (valid_from_inst_fetcher),
    .addr_from_inst_fetcher     (addr_from_inst_fetcher),
    .ready_to_inst_fetcher      (ready_to_inst_fetcher),
    .cache_line_to_inst_fetcher (cache_line_to_inst_fetcher),
    .valid_from_lsu             (valid_from_lsu),
    .wr_from_lsu                (wr_from_lsu),
    .addr_from_lsu              (addr_from_lsu),
    .len_from_lsu               (len_from_lsu),
    .data_from_lsu              (data_from_lsu),
    .ready_to_lsu               (ready_to_lsu),
    .data_to_lsu                (data_to_lsu),
    .mem_din                    (mem_din),
    .mem_dout                   (mem_dout),
    .mem_a                      (mem_a),
    .mem_wr                     (mem_wr),
    .io_buffer_full             (io_buffer_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM model.
  always @(posedge clk) mem_din <= mem_a[7:0] ^ 8'h5A;

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [LINE_W-1:0] model_line(input logic [31:0] addr);
    logic [LINE_W-1:0] l;
    logic [31:0]       b;
    b = addr & ~32'(LINE_BYTES - 1);
    l = '0;
    for (int i = 0; i < LINE_BYTES; i++) l[8*i +: 8] = ram_byte(b + 32'(i));
    return l;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input int n);
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < n; i++) d[8*i +: 8] = ram_byte(addr + 32'(i));
    return d;
  endfunction

  task automatic check_output(input string tag, input logic [LINE_W-1:0] obs,
                              input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_output({tag, "_rdy_if"},  LINE_W'(ready_to_inst_fetcher), '0);
    check_output({tag, "_rdy_lsu"}, LINE_W'(ready_to_lsu), '0);
    check_output({tag, "_line"},    cache_line_to_inst_fetcher, '0);
    check_output({tag, "_data"},    LINE_W'(data_to_lsu), '0);
    check_output({tag, "_mem_a"},   LINE_W'(mem_a), '0);
    check_output({tag, "_mem_dout"}, LINE_W'(mem_dout), '0);
    check_output({tag, "_mem_wr"},  LINE_W'(mem_wr), '0);
  endtask

  // Response scoreboard: each ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    resp_t e;
    if (ready_to_inst_fetcher === 1'b1 || ready_to_lsu === 1'b1) begin
      check_output("resp_expected", LINE_W'(resp_q.size() != 0), LINE_W'(1));
      if (resp_q.size() != 0) begin
        e = resp_q.pop_front();
        check_output("resp_port_if",  LINE_W'(ready_to_inst_fetcher), LINE_W'(e.is_if));
        check_output("resp_port_lsu", LINE_W'(ready_to_lsu), LINE_W'(!e.is_if));
        check_output("resp_cycle",    LINE_W'(cyc), LINE_W'(e.exp_cyc));
        if (e.is_if) check_output("line", cache_line_to_inst_fetcher, e.line);
        else if (e.chk_data) check_output("load_data", LINE_W'(data_to_lsu), LINE_W'(e.data));
      end
    end
  end

  // Write scoreboard: every cycle with mem_wr high must be an expected byte.
  always @(negedge clk) begin
    wr_t w;
    if (mem_wr === 1'b1) begin
      check_output("wr_expected", LINE_W'(wr_q.size() != 0), LINE_W'(1));
      if (wr_q.size() != 0) begin
        w = wr_q.pop_front();
        check_output("wr_addr", LINE_W'(mem_a), LINE_W'(w.a));
        check_output("wr_data", LINE_W'(mem_dout), LINE_W'(w.d));
      end
    end
  end

  // Called just after a falling edge; accept_delay counts edges until the
  // controller is free, extra counts stalled or frozen edges.
  task automatic raise_if(input logic [31:0] addr, input int accept_delay);
    resp_t e;
    valid_from_inst_fetcher = 1'b1;
    addr_from_inst_fetcher  = addr;
    e.is_if    = 1'b1;
    e.line     = model_line(addr);
    e.data     = '0;
    e.chk_data = 1'b0;
    e.exp_cyc  = cyc + 1 + accept_delay + LINE_BYTES + 1;
    resp_q.push_back(e);
  endtask

  task automatic raise_lsu(input logic wr, input logic [31:0] addr, input logic [1:0] len,
                           input logic [31:0] data, input int extra);
    resp_t e;
    wr_t   w;
    int    n;
    n = int'(len) + 1;
    valid_from_lsu = 1'b1;
    wr_from_lsu    = wr;
    addr_from_lsu  = addr;
    len_from_lsu   = len;
    data_from_lsu  = data;
    e.is_if    = 1'b0;
    e.line     = '0;
    e.data     = model_load(addr, n);
    e.chk_data = !wr;
    e.exp_cyc  = cyc + 1 + n + (wr ? 0 : 1) + extra;
    resp_q.push_back(e);
    if (wr) begin
      for (int i = 0; i < n; i++) begin
        w.a = addr + 32'(i);
        w.d = data[8*i +: 8];
        wr_q.push_back(w);
      end
    end
  endtask

  task automatic wait_ready(input bit is_if, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (is_if ? (ready_to_inst_fetcher === 1'b1) : (ready_to_lsu === 1'b1)) seen = 1'b1;
    end
    if (is_if) valid_from_inst_fetcher = 1'b0;
    else valid_from_lsu = 1'b0;
    check_output({tag, "_done"}, LINE_W'(seen), LINE_W'(1));
  endtask

  initial begin
    rst                     = 1'b0;
    rdy                     = 1'b1;
    valid_from_inst_fetcher = 1'b0;
    addr_from_inst_fetcher  = '0;
    valid_from_lsu          = 1'b0;
    wr_from_lsu             = 1'b0;
    addr_from_lsu           = '0;
    len_from_lsu            = '0;
    data_from_lsu           = '0;
    io_buffer_full          = 1'b0;

    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;

    // Line fill aborted by a two-cycle reset: no ready pulse may appear.
    @(negedge clk);
    valid_from_inst_fetcher = 1'b1;
    addr_from_inst_fetcher  = 32'h0000_5008;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    valid_from_inst_fetcher = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("midreset");
    rst = 1'b1;

    // Line fill from an unaligned address.
    @(negedge clk);
    raise_if(32'h0000_1004, 0);
    @(negedge clk);
    check_output("if_first_addr", LINE_W'(mem_a), LINE_W'(32'h0000_1000));
    repeat (15) @(negedge clk);
    check_output("if_last_addr", LINE_W'(mem_a), LINE_W'(32'h0000_100F));
    check_output("if_line_lo_hi", LINE_W'({model_line(32'h1004)[127:120], model_line(32'h1004)[7:0]}),
                 LINE_W'(16'h555A));
    wait_ready(1'b1, "if_line");

    // Loads: word, byte, and a half that wraps the address space.
    @(negedge clk);
    raise_lsu(1'b0, 32'h0000_2002, 2'd3, '0, 0);
    wait_ready(1'b0, "load_word");
    check_output("load_word_value", LINE_W'(data_to_lsu), LINE_W'(32'h5F5E_5958));
    @(negedge clk);
    raise_lsu(1'b0, 32'h0000_0010, 2'd0, '0, 0);
    wait_ready(1'b0, "load_byte");
    @(negedge clk);
    raise_lsu(1'b0, 32'hFFFF_FFFF, 2'd1, '0, 0);
    wait_ready(1'b0, "load_half_wrap");

    // Unstalled misaligned word store as the rdy-high reference.
    @(negedge clk);
    raise_lsu(1'b1, 32'h0000_4001, 2'd3, 32'hA1B2_C3D4, 0);
    wait_ready(1'b0, "store_word");

    // IO store held off by a full buffer for three edges.
    @(negedge clk);
    io_buffer_full = 1'b1;
    raise_lsu(1'b1, 32'h0003_0000, 2'd0, 32'h0000_0041, 3);
    repeat (3) @(negedge clk);
    io_buffer_full = 1'b0;
    wait_ready(1'b0, "store_io");

    // Word store frozen for four cycles after its second byte.
    @(negedge clk);
    raise_lsu(1'b1, 32'h0000_6000, 2'd3, 32'h1122_3344, 4);
    repeat (2) @(negedge clk);
    rdy = 1'b0;
    repeat (4) @(negedge clk);
    rdy = 1'b1;
    wait_ready(1'b0, "store_frozen");

    // Simultaneous requests: LSU half load first, then the line fill.
    @(negedge clk);
    raise_lsu(1'b0, 32'h0000_7000, 2'd1, '0, 0);
    raise_if(32'h0000_80F0, 5);
    wait_ready(1'b0, "both_lsu");
    wait_ready(1'b1, "both_if");

    repeat (3) @(negedge clk);
    check_output("resp_q_drained", LINE_W'(resp_q.size()), '0);
    check_output("wr_q_drained", LINE_W'(wr_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
